// File: rtl/ram_16k_fifo_ctrl.sv
// ram_16k_fifo_ctrl
// Single-clock FIFO controller that drives port pair 0 of a RAM_16K_BLK macro.
// It owns the pointers, occupancy, status and error flags. The RAM itself lives
// outside this block and returns read data one cycle after a read-enabled edge.
module ram_16k_fifo_ctrl #(
  parameter int addr_int        = 9,
  parameter int data_width_int  = 36,
  parameter int wr_enable_int   = 4,
  parameter int almost_full_th  = 508,
  parameter int almost_empty_th = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Flush,
  input  logic                      Push,
  input  logic [data_width_int-1:0] Push_Data,
  input  logic                      Pop,
  output logic [data_width_int-1:0] Pop_Data,
  output logic                      Pop_Valid,
  output logic                      Full,
  output logic                      Empty,
  output logic                      Almost_Full,
  output logic                      Almost_Empty,
  output logic [addr_int:0]         Level,
  output logic                      Overflow,
  output logic                      Underflow,
  output logic [addr_int-1:0]       Ram_WA,
  output logic [addr_int-1:0]       Ram_RA,
  output logic [data_width_int-1:0] Ram_WD,
  output logic [wr_enable_int-1:0]  Ram_WEN,
  output logic                      Ram_WClk_En,
  output logic                      Ram_RClk_En,
  input  logic [data_width_int-1:0] Ram_RD
);

  localparam logic [addr_int:0] DEPTH_L = (addr_int+1)'(2**addr_int);
  localparam logic [addr_int:0] AF_TH   = (addr_int+1)'(almost_full_th);
  localparam logic [addr_int:0] AE_TH   = (addr_int+1)'(almost_empty_th);

  logic [addr_int-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_int-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_int:0]   level_q, level_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;
  logic                afull_q, afull_d;
  logic                aempty_q, aempty_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                pop_valid_q, pop_valid_d;
  logic                push_acc;
  logic                pop_acc;

  // Acceptance uses only registered flags, so a push at Full or a pop at Empty
  // is refused even when the opposite side is accepted in the same cycle; this
  // also keeps the RAM from reading and writing one address in a single cycle.
  always_comb begin
    push_acc = Push & ~full_q  & ~Flush;
    pop_acc  = Pop  & ~empty_q & ~Flush;
  end

  // Next-state for pointers, occupancy, flags and sticky errors.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    pop_valid_d = pop_acc;
    if (Flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      pop_valid_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + addr_int'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + addr_int'(1);
      if (push_acc && !pop_acc) level_d = level_q + (addr_int+1)'(1);
      if (pop_acc && !push_acc) level_d = level_q - (addr_int+1)'(1);
      if (Push && full_q)  ovf_d = 1'b1;
      if (Pop  && empty_q) unf_d = 1'b1;
    end
    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == '0);
    afull_d  = (level_d >= AF_TH);
    aempty_d = (level_d <= AE_TH);
  end

  // State register; reset puts the FIFO in the empty, error-free state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      pop_valid_q <= pop_valid_d;
    end
  end

  // RAM-side controls are combinational so the macro samples them on the same
  // edge that commits the controller state.
  always_comb begin
    Ram_WA      = wr_ptr_q;
    Ram_WD      = Push_Data;
    Ram_WEN     = {wr_enable_int{push_acc}};
    Ram_WClk_En = push_acc;
    Ram_RA      = rd_ptr_q;
    Ram_RClk_En = pop_acc;
  end

  // Status and data outputs.
  always_comb begin
    Pop_Data     = Ram_RD;
    Pop_Valid    = pop_valid_q;
    Full         = full_q;
    Empty        = empty_q;
    Almost_Full  = afull_q;
    Almost_Empty = aempty_q;
    Level        = level_q;
    Overflow     = ovf_q;
    Underflow    = unf_q;
  end

endmodule

// File: tb/tb_ram_16k_fifo_ctrl.sv
// Testbench for ram_16k_fifo_ctrl: behavioural RAM, queue-based FIFO model,
// and a scoreboard monitor that compares read data whenever Pop_Valid is high.
module tb_ram_16k_fifo_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 36;
  localparam int WW    = 4;
  localparam int DEPTH = 512;
  localparam int AF_TH = 508;
  localparam int AE_TH = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   level;
  logic          overflow, underflow;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [DW-1:0] ram_wd;
  logic [WW-1:0] ram_wen;
  logic          ram_wclk_en, ram_rclk_en;
  logic [DW-1:0] ram_rd;

  logic [DW-1:0] mem [0:DEPTH-1];

  // Reference model state
  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] exp_q  [$];
  int            wr_cnt_m;
  int            rd_cnt_m;
  bit            ovf_m;
  bit            unf_m;
  bit            pv_m;

  int check_count;
  int pass_count;

  ram_16k_fifo_ctrl #(
    .addr_int(AW), .data_width_int(DW), .wr_enable_int(WW),
    .almost_full_th(AF_TH), .almost_empty_th(AE_TH)
  ) dut (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush),
    .Push(push), .Push_Data(push_data),
    .Pop(pop), .Pop_Data(pop_data), .Pop_Valid(pop_valid),
    .Full(full), .Empty(empty), .Almost_Full(almost_full), .Almost_Empty(almost_empty),
    .Level(level), .Overflow(overflow), .Underflow(underflow),
    .Ram_WA(ram_wa), .Ram_RA(ram_ra), .Ram_WD(ram_wd), .Ram_WEN(ram_wen),
    .Ram_WClk_En(ram_wclk_en), .Ram_RClk_En(ram_rclk_en), .Ram_RD(ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with one-cycle read latency (unregistered output mode)
  always @(posedge clk) begin
    if (ram_wclk_en && ram_wen != '0) mem[ram_wa] <= ram_wd;
    if (ram_rclk_en) ram_rd <= mem[ram_ra];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every valid read word must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && pop_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL pop_valid_unexpected: got 1 expected 0 at %0t", $time);
      end else begin
        checkOutput("pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic reset_model();
    fifo_m.delete();
    exp_q.delete();
    wr_cnt_m = 0;
    rd_cnt_m = 0;
    ovf_m    = 0;
    unf_m    = 0;
    pv_m     = 0;
  endtask

  task automatic check_state();
    int n;
    n = fifo_m.size();
    checkOutput("level",        64'(level),        64'(n));
    checkOutput("full",         64'(full),         64'(n == DEPTH));
    checkOutput("empty",        64'(empty),        64'(n == 0));
    checkOutput("almost_full",  64'(almost_full),  64'(n >= AF_TH));
    checkOutput("almost_empty", 64'(almost_empty), 64'(n <= AE_TH));
    checkOutput("overflow",     64'(overflow),     64'(ovf_m));
    checkOutput("underflow",    64'(underflow),    64'(unf_m));
    checkOutput("pop_valid",    64'(pop_valid),    64'(pv_m));
  endtask

  // One clock cycle of stimulus, checked against the model before and after
  task automatic applyStimulus(input bit p, input bit q, input bit f, input logic [DW-1:0] d);
    int  n;
    bit  pa, qa;
    @(negedge clk);
    check_state();
    push = p; pop = q; flush = f; push_data = d;
    #1;
    n  = fifo_m.size();
    pa = p && (n != DEPTH) && !f;
    qa = q && (n != 0) && !f;
    checkOutput("ram_wclk_en", 64'(ram_wclk_en), 64'(pa));
    checkOutput("ram_rclk_en", 64'(ram_rclk_en), 64'(qa));
    checkOutput("ram_wen",     64'(ram_wen),     pa ? 64'hF : 64'h0);
    if (pa) begin
      checkOutput("ram_wa", 64'(ram_wa), 64'(wr_cnt_m % DEPTH));
      checkOutput("ram_wd", 64'(ram_wd), 64'(d));
    end
    if (qa) checkOutput("ram_ra", 64'(ram_ra), 64'(rd_cnt_m % DEPTH));
    @(posedge clk);
    if (f) begin
      fifo_m.delete();
      wr_cnt_m = 0;
      rd_cnt_m = 0;
      ovf_m    = 0;
      unf_m    = 0;
    end else begin
      if (p && n == DEPTH) ovf_m = 1;
      if (q && n == 0)     unf_m = 1;
      if (qa) begin
        exp_q.push_back(fifo_m.pop_front());
        rd_cnt_m++;
      end
      if (pa) begin
        fifo_m.push_back(d);
        wr_cnt_m++;
      end
    end
    pv_m = qa;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  initial begin
    check_count = 0;
    pass_count  = 0;
    reset_model();
    rst_n = 1'b0; flush = 0; push = 0; pop = 0; push_data = '0;

    // Reset state, including RAM enables held low
    repeat (3) @(negedge clk);
    check_state();
    checkOutput("reset_wclk_en", 64'(ram_wclk_en), 64'h0);
    checkOutput("reset_rclk_en", 64'(ram_rclk_en), 64'h0);
    rst_n = 1'b1;

    // Idle
    repeat (10) applyStimulus(0, 0, 0, '0);

    // Fill with 0..511 then drain in order
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, DW'(i));
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);

    // Prefill three words, then sustained streaming with wrap-around
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, rand_word());
    for (int i = 0; i < 2000; i++) applyStimulus(1, 1, 0, rand_word());

    // Full boundary: fill, then push and pop together
    while (fifo_m.size() < DEPTH) applyStimulus(1, 0, 0, rand_word());
    applyStimulus(1, 1, 0, rand_word());
    repeat (3) applyStimulus(0, 0, 0, '0);

    // Empty boundary: drain, then push and pop together
    while (fifo_m.size() > 0) applyStimulus(0, 1, 0, '0);
    applyStimulus(1, 1, 0, rand_word());
    repeat (2) applyStimulus(0, 0, 0, '0);

    // Flush with traffic at level 100 while an error flag is set
    while (fifo_m.size() < 100) applyStimulus(1, 0, 0, rand_word());
    applyStimulus(1, 1, 1, rand_word());
    applyStimulus(1, 0, 0, rand_word());
    applyStimulus(0, 1, 0, '0);
    repeat (2) applyStimulus(0, 0, 0, '0);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 199) == 0), rand_word());

    // Asynchronous reset mid-stream
    while (fifo_m.size() < 20) applyStimulus(1, 1'($urandom_range(0, 1)), 0, rand_word());
    @(negedge clk);
    #2;
    push = 0; pop = 0; flush = 0;
    rst_n = 1'b0;
    #1;
    reset_model();
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, rand_word());
    for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, '0);

    // Allow outstanding reads to reach the monitor, bounded
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
